// File: rtl/bram_sched_pkg.sv
// Shared definitions for the BRAM load scheduler.
//
// Contents:
//   state_e             burst sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   STATE_W             width of the state encoding
//   DEFAULT_RD_LATENCY  default BRAM read latency, address cycle to valid dout
//   idWidth()           bits needed to hold an index in 0..n-1 (minimum 1)
package bram_sched_pkg;

  localparam int STATE_W            = 2;
  localparam int DEFAULT_RD_LATENCY = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index width with a floor of one bit, so single-entry ranges still
  // produce a legal vector declaration.
  function automatic int idWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select for the BRAM load scheduler.
//
// Default build: round-robin. The search begins at ptr_i and wraps modulo
// NUM_REQ; the first requester found wins.
// With BRAM_SCHED_PRIORITY_EN defined: fixed priority, the lowest index wins,
// and the pointer port does not exist.
//
// Ports:
//   req_i     in   NUM_REQ  request vector
//   ptr_i     in   ID_W     round-robin search start (default build only)
//   valid_o   out  1        at least one request present
//   winner_o  out  ID_W     index of the selected requester
module rr_arbiter
  import bram_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef BRAM_SCHED_PRIORITY_EN
  input  logic [ID_W-1:0]    ptr_i,
`endif
  output logic               valid_o,
  output logic [ID_W-1:0]    winner_o
);

`ifdef BRAM_SCHED_PRIORITY_EN
  // Walk from the highest index down, so the lowest requesting index is
  // the last one written and therefore wins.
  always_comb begin
    valid_o  = |req_i;
    winner_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[ID_W'(i)]) begin
        winner_o = ID_W'(i);
      end
    end
  end
`else
  // Walk the rotated order from the farthest offset back toward ptr_i.
  // The candidate closest to the pointer is written last and wins.
  always_comb begin
    int cand;
    valid_o  = |req_i;
    winner_o = '0;
    cand     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[ID_W'(cand)]) begin
        winner_o = ID_W'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/bram_load_scheduler.sv
// Arbitrates one shared parameter BRAM between NUM_REQ loaders and sequences
// each granted read burst. The scheduler issues one address per cycle and
// returns each element tagged with its owner ID and element index.
//
// Configuration macro: BRAM_SCHED_PRIORITY_EN selects fixed priority, where
// the lowest index wins. When the macro is undefined the scheduler uses
// round-robin arbitration.
//
// Ports:
//   clk_i        in   1                     system clock, rising edge
//   rst_ni       in   1                     asynchronous active-low reset
//   req_i        in   NUM_REQ               level request per loader
//   req_base_i   in   NUM_REQ*ADDR_WIDTH    packed start address per loader
//   req_len_i    in   NUM_REQ*LEN_WIDTH     packed element count per loader
//   grant_o      out  NUM_REQ               one-hot owner for the whole burst
//   done_o       out  NUM_REQ               one-cycle pulse at burst end
//   rd_valid_o   out  1                     returned element valid
//   rd_data_o    out  W                     returned element
//   rd_id_o      out  clog2(NUM_REQ)        owner of the returned element
//   rd_idx_o     out  LEN_WIDTH             element index within the burst
//   busy_o       out  1                     sequencer not idle
//   bram_en_o    out  1                     BRAM enable
//   bram_ren_o   out  1                     BRAM read enable
//   bram_addr_o  out  ADDR_WIDTH            BRAM address
//   bram_dout_i  in   W                     BRAM read data
module bram_load_scheduler
  import bram_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  localparam int ID_W      = idWidth(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            rd_valid_o,
  output logic [W-1:0]                    rd_data_o,
  output logic [ID_W-1:0]                 rd_id_o,
  output logic [LEN_WIDTH-1:0]            rd_idx_o,
  output logic                            busy_o,
  output logic                            bram_en_o,
  output logic                            bram_ren_o,
  output logic [ADDR_WIDTH-1:0]           bram_addr_o,
  input  logic [W-1:0]                    bram_dout_i
);

  localparam int DRAIN_W = idWidth(RD_LATENCY);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;

  logic                  arbValid;
  logic [ID_W-1:0]       arbWinner;
  logic [ADDR_WIDTH-1:0] baseArr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  lenArr  [NUM_REQ];

  logic                  pipeValid_q [RD_LATENCY];
  logic [ID_W-1:0]       pipeId_q    [RD_LATENCY];
  logic [LEN_WIDTH-1:0]  pipeIdx_q   [RD_LATENCY];
  logic                  issueValid;

  // Unpack the per-loader base and length fields so that the winner can
  // select them with a narrow index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign baseArr[g] = req_base_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign lenArr[g]  = req_len_i[g*LEN_WIDTH +: LEN_WIDTH];
  end

`ifndef BRAM_SCHED_PRIORITY_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // The round-robin pointer holds the search start for the next grant.
  // It moves only when a grant is made.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && arbValid) begin
      ptr_d = (arbWinner == ID_W'(NUM_REQ - 1)) ? '0 : arbWinner + ID_W'(1);
    end
  end
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i    (req_i),
`ifndef BRAM_SCHED_PRIORITY_EN
    .ptr_i    (ptr_q),
`endif
    .valid_o  (arbValid),
    .winner_o (arbWinner)
  );

  // Sequencer state and the fields latched from the winning request.
  // Base and length are captured at grant time, so later changes on the
  // request inputs do not affect the burst in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic. In ISSUE, addr_q advances every cycle and wraps
  // naturally at the address width. In DRAIN, the sequencer waits
  // RD_LATENCY cycles so that the last element returns before done.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arbValid) begin
          owner_d = arbWinner;
          addr_d  = baseArr[arbWinner];
          len_d   = lenArr[arbWinner];
          k_d     = '0;
          drain_d = '0;
          state_d = (lenArr[arbWinner] == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (k_q == len_q - LEN_WIDTH'(1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + LEN_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(RD_LATENCY - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign issueValid = (state_q == ST_ISSUE);

  // The return path tags each issued address with its owner and index.
  // The tag is delayed by RD_LATENCY so it lines up with bram_dout.
  // A reset clears the valid bits, which discards any data in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeId_q[i]    <= '0;
        pipeIdx_q[i]   <= '0;
      end
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeId_q[i]    <= pipeId_q[i-1];
        pipeIdx_q[i]   <= pipeIdx_q[i-1];
      end
      pipeValid_q[0] <= issueValid;
      pipeId_q[0]    <= owner_q;
      pipeIdx_q[0]   <= k_q;
    end
  end

  // Outputs decode directly from the state register. This way an
  // asynchronous reset forces every output to zero at once. The return
  // fields are zero whenever rd_valid_o is low.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    grant_o     = busy_o ? (NUM_REQ'(1) << owner_q) : '0;
    done_o      = (state_q == ST_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
    bram_en_o   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    bram_ren_o  = issueValid;
    bram_addr_o = issueValid ? addr_q : '0;
    rd_valid_o  = pipeValid_q[RD_LATENCY-1];
    rd_data_o   = rd_valid_o ? bram_dout_i : '0;
    rd_id_o     = rd_valid_o ? pipeId_q[RD_LATENCY-1] : '0;
    rd_idx_o    = rd_valid_o ? pipeIdx_q[RD_LATENCY-1] : '0;
  end

endmodule
